// File: rtl/instruction_fetch.sv
// instruction_fetch: RV64 fetch stage with one outstanding imem request and a
// two-entry (output register + skid) buffer toward decode; redirect flushes and squashes.
module instruction_fetch #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_INC   = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [6:0]      if_opcode
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
    logic [31:0]     out_instr_q, out_instr_d, skid_instr_q, skid_instr_d;
    logic            out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, drop_q, drop_d;
    logic            req_fire, pop, resp_take, head_vld;

    assign imem_req_valid = (state_q == REQ) && !(out_vld_q && skid_vld_q);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pop            = out_vld_q && if_ready;
    assign resp_take      = (state_q == WAIT) && imem_resp_valid && !drop_q && !redirect_valid;
    // occupancy of the output register after this cycle's pop and skid shift
    assign head_vld       = pop ? skid_vld_q : out_vld_q;

    assign if_valid  = out_vld_q;
    assign if_instr  = out_instr_q;
    assign if_pc     = out_pc_q;
    assign if_opcode = out_instr_q[6:0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        out_vld_d    = head_vld;
        out_instr_d  = pop ? skid_instr_q : out_instr_q;
        out_pc_d     = pop ? skid_pc_q : out_pc_q;
        skid_vld_d   = skid_vld_q && !pop;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (resp_take) begin
            if (!head_vld) begin
                out_vld_d   = 1'b1;
                out_instr_d = imem_resp_data;
                out_pc_d    = pc_q;
            end else begin
                skid_vld_d   = 1'b1;
                skid_instr_d = imem_resp_data;
                skid_pc_d    = pc_q;
            end
            pc_d = pc_q + XLEN'(PC_INC);
        end
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (req_fire) begin
                    state_d = WAIT;
                    drop_d  = redirect_valid;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    state_d = REQ;
                    drop_d  = 1'b0;
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // redirect wins over everything: new word-aligned pc, buffers flushed
        if (redirect_valid) begin
            pc_d       = redirect_pc & ~XLEN'(3);
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            out_vld_q    <= 1'b0;
            out_instr_q  <= '0;
            out_pc_q     <= '0;
            skid_vld_q   <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            out_vld_q    <= out_vld_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_vld_q   <= skid_vld_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end
endmodule
